// File: rtl/led_frame_receiver_if.sv
// led_frame_receiver_if: optical receive link bundle; master drives signal, slave returns data_out/irq_rx/frame_error/busy
`timescale 1ns/1ps
`ifndef PACKET_SIZE
`define PACKET_SIZE 8
`endif
interface led_frame_receiver_if #(parameter int PACKET_SIZE = `PACKET_SIZE);
   logic                   signal;
   logic [PACKET_SIZE-1:0] data_out;
   logic                   irq_rx;
   logic                   frame_error;
   logic                   busy;
   modport master(output signal, input data_out, irq_rx, frame_error, busy);
   modport slave(input signal, output data_out, irq_rx, frame_error, busy);
endinterface

// File: rtl/led_frame_receiver.sv
// led_frame_receiver: resync, oversample and deframe start|data MSB-first|[parity]|stop words; ports clock, reset (async high), lnk.slave (signal in; data_out, irq_rx, frame_error, busy out); optional even parity bit under LIGHT_RX_PARITY_EN
`timescale 1ns/1ps
`ifndef PACKET_SIZE
`define PACKET_SIZE 8
`endif
module led_frame_receiver #(
   parameter int PACKET_SIZE = `PACKET_SIZE,
   parameter int BIT_CYCLES  = 16,
   parameter int CNT_W       = 8
) (
   input logic                 clock,
   input logic                 reset,
   led_frame_receiver_if.slave lnk
);
   localparam int IDX_W = PACKET_SIZE > 1 ? $clog2(PACKET_SIZE) : 1;
`ifdef LIGHT_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif
   state_t                 state_q, state_d;
   logic [1:0]             sync_q, sync_d;
   logic [CNT_W-1:0]       timer_q, timer_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [PACKET_SIZE-1:0] shift_q, shift_d, data_q, data_d;
   logic                   irq_q, irq_d, ferr_q, ferr_d;
   logic                   s, mid, ok;
`ifdef LIGHT_RX_PARITY_EN
   logic                   par_err_q, par_err_d;
`endif
   assign s = sync_q[1];
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         sync_q  <= '0;
         timer_q <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         irq_q   <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef LIGHT_RX_PARITY_EN
         par_err_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         timer_q <= timer_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         irq_q   <= irq_d;
         ferr_q  <= ferr_d;
`ifdef LIGHT_RX_PARITY_EN
         par_err_q <= par_err_d;
`endif
      end
   end
   always_comb begin
      sync_d  = {sync_q[0], lnk.signal};
      state_d = state_q;
      timer_d = timer_q + 1'b1;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      irq_d   = 1'b0;
      ferr_d  = 1'b0;
      mid     = timer_q == CNT_W'(BIT_CYCLES - 1);
`ifdef LIGHT_RX_PARITY_EN
      par_err_d = par_err_q;
      ok        = !s && !par_err_q;
`else
      ok        = !s;
`endif
      case (state_q)
         IDLE: begin
            // the IDLE cycle that first sees s=1 is tick 0 of the start bit
            timer_d = {{(CNT_W-1){1'b0}}, s};
            state_d = s ? START : IDLE;
         end
         START: if (timer_q == CNT_W'(BIT_CYCLES/2 - 1)) begin
            timer_d = '0;
            idx_d   = IDX_W'(PACKET_SIZE - 1);
            state_d = s ? DATA : IDLE;
         end
         DATA: if (mid) begin
            timer_d = '0;
            shift_d = PACKET_SIZE'({shift_q, s});
            idx_d   = idx_q - 1'b1;
`ifdef LIGHT_RX_PARITY_EN
            state_d = idx_q == '0 ? PARITY : DATA;
`else
            state_d = idx_q == '0 ? STOP : DATA;
`endif
         end
`ifdef LIGHT_RX_PARITY_EN
         PARITY: if (mid) begin
            timer_d   = '0;
            par_err_d = s ^ (^shift_q);
            state_d   = STOP;
         end
`endif
         STOP: if (mid) begin
            timer_d = '0;
            irq_d   = ok;
            ferr_d  = !ok;
            data_d  = ok ? shift_q : data_q;
            state_d = ok ? IDLE : WAIT_IDLE;
         end
         WAIT_IDLE: begin
            timer_d = '0;
            state_d = s ? WAIT_IDLE : IDLE;
         end
         default: begin
            timer_d = '0;
            state_d = IDLE;
         end
      endcase
   end
   always_comb begin
      lnk.busy        = state_q != IDLE;
      lnk.data_out    = data_q;
      lnk.irq_rx      = irq_q;
      lnk.frame_error = ferr_q;
   end
endmodule
